// File: rtl/rpc_pkg.sv
// rtl/rpc_pkg.sv - state encoding and default widths for record_playback_ctrl
package rpc_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_RECORD = 2'd2,
        S_PLAY   = 2'd3
    } rpc_state_t;

    localparam int RPC_ADDR_W = 8;
    localparam int RPC_DUTY_W = 6;
    localparam int RPC_TICK_W = 12;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchroniser followed by a registered rising-edge pulse
module btn_edge (
    input  logic sysclk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
            rise  <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/record_playback_ctrl.sv
// rtl/record_playback_ctrl.sv - record/playback/clear sequencer for the servo duty memory
// RPC_LOOP_EN: playback wraps and repeats; otherwise it stops after the last sample.
module record_playback_ctrl
    import rpc_pkg::*;
#(
    parameter int ADDR_W = RPC_ADDR_W,
    parameter int DUTY_W = RPC_DUTY_W,
    parameter int TICK_W = RPC_TICK_W
) (
    input  logic              sysclk,
    input  logic              Reset_Sw,
    input  logic              Storage_Sw,
    input  logic              Play_Sw,
    input  logic              Clear_Sw,
    input  logic              Bt_Up,
    input  logic              Bt_Down,
    input  logic              Bt_Left,
    input  logic              Bt_Right,
    input  logic [DUTY_W-1:0] Duty_X,
    input  logic [DUTY_W-1:0] Duty_Y,
    input  logic [DUTY_W-1:0] Mem_Rdata_X,
    input  logic [DUTY_W-1:0] Mem_Rdata_Y,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DUTY_W-1:0] Mem_Wdata_X,
    output logic [DUTY_W-1:0] Mem_Wdata_Y,
    output logic [DUTY_W-1:0] DC_X,
    output logic [DUTY_W-1:0] DC_Y,
    output logic [ADDR_W:0]   Rec_Len,
    output logic              Full,
    output logic [1:0]        State,
    output logic              Done
);

    rpc_state_t        state, next_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [TICK_W-1:0] tick;
    logic [ADDR_W:0]   rec_len_q;
    logic [DUTY_W-1:0] dc_x, dc_y;
    logic              play_q;
    logic              done_q;
    logic              btn_rise;
    logic              rec_write;
    logic              play_last;
    logic              play_ok;
    logic              play_stop;

    btn_edge u_btn_edge (
        .sysclk (sysclk),
        .rst    (Reset_Sw),
        .din    (Bt_Up | Bt_Down | Bt_Left | Bt_Right),
        .rise   (btn_rise)
    );

    assign play_last = (state == S_PLAY) && (&tick) && (rec_len_q != '0) &&
                       ({1'b0, rd_ptr} == rec_len_q - (ADDR_W + 1)'(1));

`ifdef RPC_LOOP_EN
    assign play_ok   = Play_Sw;
    assign play_stop = 1'b0;
`else
    logic play_rise;
    logic armed;

    btn_edge u_play_edge (
        .sysclk (sysclk),
        .rst    (Reset_Sw),
        .din    (Play_Sw),
        .rise   (play_rise)
    );

    // A finished playback disarms until Play_Sw is seen going low and high again.
    always_ff @(posedge sysclk) begin
        if (Reset_Sw)       armed <= 1'b1;
        else if (play_last) armed <= 1'b0;
        else if (play_rise) armed <= 1'b1;
    end

    assign play_ok   = Play_Sw & (armed | play_rise);
    assign play_stop = play_last;
`endif

    always_comb begin
        next_state  = state;
        rec_write   = 1'b0;
        Mem_We      = 1'b0;
        Mem_Addr    = '0;
        Mem_Wdata_X = '0;
        Mem_Wdata_Y = '0;
        case (state)
            S_CLEAR: begin
                if (&clr_cnt) next_state = S_IDLE;
            end
            default: begin
                if (Clear_Sw)                    next_state = S_CLEAR;
                else if (Storage_Sw)             next_state = S_RECORD;
                else if (play_ok && !play_stop)  next_state = S_PLAY;
                else                             next_state = S_IDLE;
            end
        endcase
        // An edge on the cycle that leaves RECORD is dropped.
        rec_write = (state == S_RECORD) && btn_rise && !Full && (next_state == S_RECORD);
        case (state)
            S_CLEAR: begin
                Mem_We   = 1'b1;
                Mem_Addr = clr_cnt;
            end
            S_RECORD: begin
                Mem_We      = rec_write;
                Mem_Addr    = rec_len_q[ADDR_W-1:0];
                Mem_Wdata_X = Duty_X;
                Mem_Wdata_Y = Duty_Y;
            end
            S_PLAY:  Mem_Addr = rd_ptr;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (Reset_Sw) begin
            state     <= S_IDLE;
            clr_cnt   <= '0;
            rd_ptr    <= '0;
            tick      <= '0;
            rec_len_q <= '0;
            dc_x      <= '0;
            dc_y      <= '0;
            play_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state   <= next_state;
            play_q  <= (state == S_PLAY);
            done_q  <= play_last;
            clr_cnt <= (state == S_CLEAR) ? clr_cnt + ADDR_W'(1) : '0;

            if ((state == S_CLEAR) && (&clr_cnt)) rec_len_q <= '0;
            else if (rec_write)                   rec_len_q <= rec_len_q + (ADDR_W + 1)'(1);

            // Pointer and tick sit at zero outside PLAY, so entry always starts at sample 0.
            if (state == S_PLAY) begin
                tick <= tick + TICK_W'(1);
                if ((&tick) && (rec_len_q != '0))
                    rd_ptr <= play_last ? '0 : rd_ptr + ADDR_W'(1);
            end else begin
                tick   <= '0;
                rd_ptr <= '0;
            end

            // Read data is only trusted once the address has been PLAY's for a full cycle.
            case (state)
                S_RECORD: begin
                    dc_x <= Duty_X;
                    dc_y <= Duty_Y;
                end
                S_PLAY: begin
                    if (rec_len_q == '0) begin
                        dc_x <= '0;
                        dc_y <= '0;
                    end else if (play_q) begin
                        dc_x <= Mem_Rdata_X;
                        dc_y <= Mem_Rdata_Y;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Rec_Len = rec_len_q;
    assign Full    = rec_len_q[ADDR_W];
    assign DC_X    = dc_x;
    assign DC_Y    = dc_y;
    assign State   = state;
    assign Done    = done_q;

endmodule

// File: tb/tb_record_playback_ctrl.sv
// tb/tb_record_playback_ctrl.sv - directed self-checking bench for record_playback_ctrl
module tb_record_playback_ctrl;

    localparam int AW = 8;
    localparam int DW = 6;
    localparam int TW = 4;

    logic          sysclk = 1'b0;
    logic          Reset_Sw, Storage_Sw, Play_Sw, Clear_Sw;
    logic          Bt_Up, Bt_Down, Bt_Left, Bt_Right;
    logic [DW-1:0] Duty_X, Duty_Y, Mem_Rdata_X, Mem_Rdata_Y;
    logic          Mem_We, Full, Done;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_Wdata_X, Mem_Wdata_Y, DC_X, DC_Y;
    logic [AW:0]   Rec_Len;
    logic [1:0]    State;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [2*DW-1:0] mem [0:(1<<AW)-1];
    int wq_a[$], wq_x[$], wq_y[$], wq_c[$];
    int ex_x[3] = '{5, 20, 63};
    int ex_y[3] = '{10, 30, 0};

    always #5 sysclk = ~sysclk;

    record_playback_ctrl #(.ADDR_W(AW), .DUTY_W(DW), .TICK_W(TW)) dut (
        .sysclk(sysclk), .Reset_Sw(Reset_Sw), .Storage_Sw(Storage_Sw), .Play_Sw(Play_Sw),
        .Clear_Sw(Clear_Sw), .Bt_Up(Bt_Up), .Bt_Down(Bt_Down), .Bt_Left(Bt_Left),
        .Bt_Right(Bt_Right), .Duty_X(Duty_X), .Duty_Y(Duty_Y), .Mem_Rdata_X(Mem_Rdata_X),
        .Mem_Rdata_Y(Mem_Rdata_Y), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr),
        .Mem_Wdata_X(Mem_Wdata_X), .Mem_Wdata_Y(Mem_Wdata_Y), .DC_X(DC_X), .DC_Y(DC_Y),
        .Rec_Len(Rec_Len), .Full(Full), .State(State), .Done(Done)
    );

    // Synchronous-read sample memory, one cycle of latency.
    always @(posedge sysclk) begin
        cyc <= cyc + 1;
        if (Mem_We) mem[Mem_Addr] <= {Mem_Wdata_X, Mem_Wdata_Y};
        {Mem_Rdata_X, Mem_Rdata_Y} <= mem[Mem_Addr];
    end

    always @(negedge sysclk) begin
        if (Mem_We) begin
            wq_a.push_back(int'(Mem_Addr));
            wq_x.push_back(int'(Mem_Wdata_X));
            wq_y.push_back(int'(Mem_Wdata_Y));
            wq_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge sysclk);
        #1;
    endtask

    task automatic press(input logic [3:0] b, input int dx, input int dy);
        Duty_X = DW'(dx);
        Duty_Y = DW'(dy);
        {Bt_Up, Bt_Down, Bt_Left, Bt_Right} = b;
        repeat (4) step();
        {Bt_Up, Bt_Down, Bt_Left, Bt_Right} = 4'b0000;
        repeat (4) step();
    endtask

    function automatic int exp_idx(input int c);
        int idx;
        if (c < 3) return -1;
        idx = (c - 3) / 16;
`ifdef RPC_LOOP_EN
        return idx % 3;
`else
        return (idx > 2) ? 2 : idx;
`endif
    endfunction

    initial begin
        int k, n0, bad;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        Reset_Sw = 1'b1; Storage_Sw = 1'b0; Play_Sw = 1'b0; Clear_Sw = 1'b0;
        {Bt_Up, Bt_Down, Bt_Left, Bt_Right} = 4'b0000;
        Duty_X = '0; Duty_Y = '0;
        repeat (3) step();

        check("rst_state", State, 0);
        check("rst_reclen", Rec_Len, 0);
        check("rst_we", Mem_We, 0);
        check("rst_addr", Mem_Addr, 0);
        check("rst_dcx", DC_X, 0);
        check("rst_full", Full, 0);
        check("rst_done", Done, 0);
        Reset_Sw = 1'b0;

        // Record three samples; the first one also measures press-to-write latency.
        Storage_Sw = 1'b1;
        step();
        check("rec_state", State, 2);
        Duty_X = 6'd5; Duty_Y = 6'd10; Bt_Up = 1'b1;
        step(); check("lat_c1", Mem_We, 0);
        step(); check("lat_c2", Mem_We, 0);
        step(); check("lat_c3", Mem_We, 1);
        step(); check("lat_one", Mem_We, 0);
        Bt_Up = 1'b0;
        repeat (4) step();
        press(4'b1000, 20, 30);
        press(4'b1000, 63, 0);
        check("rec_count", wq_a.size(), 3);
        check("rec_len3", Rec_Len, 3);
        if (wq_a.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("rec_addr", wq_a[i], i);
                check("rec_x", wq_x[i], ex_x[i]);
                check("rec_y", wq_y[i], ex_y[i]);
            end
        end
        Storage_Sw = 1'b0;
        step();
        check("idle_state", State, 0);

        // Playback of 5/10, 20/30, 63/0 at 16 cycles per sample.
        Play_Sw = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            step();
            k = exp_idx(c);
            check("play_dcx", DC_X, (k < 0) ? 63 : ex_x[k]);
            check("play_dcy", DC_Y, (k < 0) ? 0 : ex_y[k]);
`ifdef RPC_LOOP_EN
            check("play_state", State, 3);
`else
            check("play_state", State, (c >= 49) ? 0 : 3);
`endif
            check("play_done", Done, (c == 49) ? 1 : 0);
        end
        Play_Sw = 1'b0;
        repeat (2) step();
        check("play_exit", State, 0);

        // Simultaneous Left+Right presses give a single write.
        Storage_Sw = 1'b1;
        step();
        n0 = wq_a.size();
        press(4'b0011, 7, 8);
        check("simul_count", wq_a.size(), n0 + 1);
        if (wq_a.size() > n0) check("simul_addr", wq_a[n0], 3);
        check("simul_len", Rec_Len, 4);
        check("rec_dcx", DC_X, 7);
        Storage_Sw = 1'b0;
        step();

        // Clear: 256 consecutive zero writes, then IDLE with an empty recording.
        wq_a.delete(); wq_x.delete(); wq_y.delete(); wq_c.delete();
        Clear_Sw = 1'b1;
        step();
        Clear_Sw = 1'b0;
        check("clr_state", State, 1);
        for (int i = 0; i < 300 && State == 2'd1; i++) step();
        check("clr_done", State, 0);
        check("clr_count", wq_a.size(), 256);
        check("clr_len", Rec_Len, 0);
        if (wq_a.size() == 256) begin
            bad = 0;
            for (int i = 0; i < 256; i++)
                if (wq_a[i] != i || wq_x[i] != 0 || wq_y[i] != 0) bad++;
            check("clr_bad", bad, 0);
            check("clr_span", wq_c[255] - wq_c[0], 255);
        end

        // Empty recording: PLAY drives zero duty and keeps address 0.
        Play_Sw = 1'b1;
        for (int i = 0; i < 10 && State != 2'd3; i++) step();
        check("p0_enter", State, 3);
        for (int c = 0; c < 20; c++) begin
            step();
            check("p0_dcx", DC_X, 0);
            check("p0_dcy", DC_Y, 0);
            check("p0_addr", Mem_Addr, 0);
        end
        Play_Sw = 1'b0;
        step();

        // Fill the memory, then one more press must be ignored.
        Storage_Sw = 1'b1;
        step();
        wq_a.delete(); wq_x.delete(); wq_y.delete(); wq_c.delete();
        for (int i = 0; i < 256; i++) press(4'b0100, i % 64, 63 - (i % 64));
        check("fill_count", wq_a.size(), 256);
        check("fill_len", Rec_Len, 256);
        check("fill_full", Full, 1);
        if (wq_a.size() == 256) begin
            check("fill_last_addr", wq_a[255], 255);
            check("fill_last_x", wq_x[255], 63);
            check("fill_last_y", wq_y[255], 0);
        end
        press(4'b0001, 1, 1);
        check("full_nowrite", wq_a.size(), 256);
        check("full_len", Rec_Len, 256);
        Storage_Sw = 1'b0;
        step();

        // Reset while clearing, right after the 100th write.
        wq_a.delete(); wq_x.delete(); wq_y.delete(); wq_c.delete();
        Clear_Sw = 1'b1;
        step();
        Clear_Sw = 1'b0;
        for (int i = 0; i < 400 && wq_a.size() < 100; i++) step();
        check("rclr_reach", wq_a.size(), 100);
        Reset_Sw = 1'b1;
        step();
        check("rclr_we", Mem_We, 0);
        check("rclr_state", State, 0);
        check("rclr_len", Rec_Len, 0);
        Reset_Sw = 1'b0;
        repeat (3) step();
        check("rclr_stopped", wq_a.size(), 100);
        check("rclr_idle", State, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
